icache_dm: RTL
==============

Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache between the single-cycle datapath fetch port (upstream: imemREN/imemaddr/ihit/imemload) and the memory controller instruction port (downstream: iREN/iaddr/iwait/iload).
- Returns hits combinationally in the same cycle.
- On a miss, runs a one-word fill transaction to memory, then serves the hit.
- Keeps hit/miss counters for the performance dump at halt.

Parameters:
- SETS, 16, number of frames; power of two; index width IDX_W = log2(SETS) = 4.
- TAG_W, 26, tag width = 32 - IDX_W - 2 (2 = byte offset).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- nRST  input  1  asynchronous, active-low reset.
- imemREN  input  1  fetch request from datapath.
- imemaddr  input  32  fetch byte address from datapath; bits [1:0] ignored.
- ihit  output  1  fetched word valid on imemload this cycle.
- imemload  output  32  instruction word to datapath.
- iREN  output  1  read request to memory controller.
- iaddr  output  32  read address to memory controller, word aligned.
- iwait  input  1  memory busy; low in the cycle iload is valid.
- iload  input  32  word returned by memory.
- hit_count  output  32  saturating count of hit cycles.
- miss_count  output  32  saturating count of miss transactions started.

Behaviour:
- Address split: tag = imemaddr[31:6], index = imemaddr[5:2], offset = imemaddr[1:0] (unused).
- Frame fields: valid (1), tag (TAG_W), data (32).

Reset (nRST low, asynchronous):
- All frames cleared (valid = 0, tag = 0, data = 0); state = IDLE; miss_addr = 0; counters = 0.
- Outputs: ihit = 0, iREN = 0, iaddr = 0, imemload = 0.

FSM states:
- IDLE:
  - hit = imemREN & frame[index].valid & (frame[index].tag == tag).
  - ihit = hit; imemload = frame[index].data when hit, else 0; iREN = 0; iaddr = 0.
  - On imemREN & !hit: latch miss_addr = {imemaddr[31:2], 2'b00}, increment miss_count, go to FILL.
- FILL:
  - iREN = 1, iaddr = miss_addr, ihit = 0.
  - When iwait = 0: write frame[miss_addr index] = {1, miss_addr tag, iload}, go to IDLE.
  - The next cycle hits when imemaddr is unchanged. Miss latency = memory latency + 1 cycle.
  - When imemREN drops while iwait = 1: abort, go to IDLE, no frame write, iREN = 0 from the next cycle.
  - When imemREN drops in the same cycle iwait = 0: complete the write; data was already returned.
  - imemaddr changes during FILL are ignored; the fill always uses miss_addr.

Counters:
- hit_count increments once per cycle with ihit = 1 (single-cycle datapath stalls on !ihit, so one fetch = one hit cycle).
- Both counters saturate at 32'hFFFFFFFF.

Other rules:
- Conflict replacement: a fill into an occupied index overwrites it unconditionally (no victim writeback; read-only).
- No self-modifying code support; dcache writes do not invalidate the icache.
- Reset mid-FILL: iREN drops immediately (asynchronous); no partial frame write.

Decomposition:
- Shared package, diaosi_types_pkg:
  - icache_state_t enum {IDLE, FILL}.
  - icache_frame_t packed struct {valid, tag[25:0], data word_t}.
  - icachef_t packed struct {tag[25:0], idx[3:0], bytoff[1:0]} for address overlay.
- word_t comes from cpu_types_pkg.
- No sub-module; the frame array and FSM live in one module. Counters are inline always_ff blocks.

Test Plan:
- Cold miss: reset, imemREN = 1, imemaddr = 0x00000040, memory iwait high 3 cycles, then iload = 0x8C010004 → iREN = 1 with iaddr = 0x40 for 4 cycles; next cycle ihit = 1, imemload = 0x8C010004; miss_count = 1, hit_count = 1.
- Hot hit: after the above, reapply 0x40 → ihit in the same cycle, iREN stays 0; 0x42 (offset ignored) also hits.
- Conflict: fill 0x40 (idx 0), then request 0x440 (same idx, tag 0x11) → miss with iaddr = 0x440; after the fill, 0x40 misses again.
- Abort: miss on 0x80, drop imemREN after 1 iwait cycle → iREN = 0 next cycle; re-request 0x80 still misses (frame not written).
- Reset mid-fill: assert nRST low during FILL → iREN = 0 and ihit = 0 immediately; after release, all prior addresses miss and both counters read 0.
- Sequential fetch 0x0..0x3C (16 words) twice → 16 misses then 16 hits: miss_count = 16, hit_count = 32.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - basic datapath word types shared across the cpu
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/diaosi_types_pkg.sv
// rtl/diaosi_types_pkg.sv - cache geometry, frame layout and address overlay
package diaosi_types_pkg;

  localparam int SETS  = 16;
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - IDX_W - 2;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } icache_state_t;

  typedef struct packed {
    logic                 valid;
    logic [TAG_W-1:0]     tag;
    cpu_types_pkg::word_t data;
  } icache_frame_t;

  // Overlay on a byte address: tag | index | byte offset.
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [1:0]       bytoff;
  } icachef_t;

endpackage

// File: rtl/icache_dm_if.sv
// rtl/icache_dm_if.sv - fetch port (datapath side) and instruction port (memory side)
interface icache_dm_if;
  import cpu_types_pkg::*;

  logic  imemREN;
  word_t imemaddr;
  logic  ihit;
  word_t imemload;

  logic  iREN;
  word_t iaddr;
  logic  iwait;
  word_t iload;

  // master: the environment (datapath fetch + memory controller)
  modport master (
    output imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );

  // slave: the cache itself
  modport slave (
    input  imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

endinterface

// File: rtl/icache_dm.sv
// rtl/icache_dm.sv - direct-mapped read-only instruction cache
// Hits are answered combinationally; a miss runs a one-word fill, then hits.
module icache_dm
  import cpu_types_pkg::*;
  import diaosi_types_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  icache_dm_if.slave  bus,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  icache_state_t state;
  icache_frame_t frames [SETS];
  icachef_t      miss_addr;
  icachef_t      req;
  icache_frame_t cur;
  logic          hit;
  logic          miss_start;
  logic          unused_bytoff;

  assign req           = icachef_t'(bus.imemaddr);
  assign cur           = frames[req.idx];
  assign unused_bytoff = ^req.bytoff;

  // Outputs decode from state only, so an async reset drops iREN at once.
  always_comb begin
    hit          = 1'b0;
    miss_start   = 1'b0;
    bus.ihit     = 1'b0;
    bus.imemload = '0;
    bus.iREN     = 1'b0;
    bus.iaddr    = '0;
    if (state == IDLE) begin
      hit          = bus.imemREN & cur.valid & (cur.tag == req.tag);
      miss_start   = bus.imemREN & ~hit;
      bus.ihit     = hit;
      bus.imemload = hit ? cur.data : '0;
    end else begin
      bus.iREN  = 1'b1;
      bus.iaddr = word_t'(miss_addr);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      miss_addr <= '0;
      frames    <= '{default: '0};
    end else begin
      case (state)
        IDLE: begin
          if (miss_start) begin
            miss_addr <= '{tag: req.tag, idx: req.idx, bytoff: 2'b00};
            state     <= FILL;
          end
        end
        FILL: begin
          // Returned data wins over a same-cycle drop of imemREN.
          if (!bus.iwait) begin
            frames[miss_addr.idx] <= '{valid: 1'b1, tag: miss_addr.tag, data: bus.iload};
            state                 <= IDLE;
          end else if (!bus.imemREN) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_count <= '0;
    end else if (hit && hit_count != 32'hFFFF_FFFF) begin
      hit_count <= hit_count + 32'd1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      miss_count <= '0;
    end else if (miss_start && miss_count != 32'hFFFF_FFFF) begin
      miss_count <= miss_count + 32'd1;
    end
  end

endmodule
